// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a LEN / data / CHK byte frame over valid/ready, packs big-endian
// 32-bit words and emits one-cycle write strobes at addresses 0..L.
module imem_loader #(
    parameter int addWidth  = 5,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [addWidth:0]    wr_addr,
    output logic [dataWidth-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 chk_err
);

    localparam int AW = addWidth + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] last_addr;
    logic [23:0]   asm_reg;
    logic [7:0]    checksum;
    logic          xfer;

    // a byte moves only when the registered ready meets the source's valid
    assign xfer = byte_valid && byte_ready;

    // frame sequencer; every output is a register updated on entry to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            last_addr  <= '0;
            asm_reg    <= '0;
            checksum   <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chk_err    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        // oversize lengths are masked to the memory depth
                        last_addr <= byte_in[AW-1:0];
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        checksum  <= '0;
                        state     <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ byte_in;
                        asm_reg  <= {asm_reg[15:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= word_cnt;
                            wr_data    <= {asm_reg, byte_in};
                            byte_ready <= 1'b0;
                            state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    // byte_cnt has already wrapped to 0 for the next word
                    byte_ready <= 1'b1;
                    if (word_cnt == last_addr) begin
                        state <= S_CHK;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= S_DATA;
                    end
                end

                S_CHK: begin
                    if (xfer) begin
                        chk_err    <= (byte_in != checksum);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        done       <= 1'b0;
                        chk_err    <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        state      <= S_LEN;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus a stream-level
// model that predicts every write from the bytes actually accepted.
module tb_imem_loader;

    localparam int AWD   = 5;
    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        chk_err;

    imem_loader #(.addWidth(AWD), .dataWidth(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          wr_count;
    logic [31:0] wr_log [DEPTH];
    logic [5:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [31:0] fw [DEPTH];

    // stream model state
    int          k;
    int          nwords;
    logic [31:0] m_word;
    logic [7:0]  m_xor;
    bit          exp_wr;
    bit          exp_fin;
    bit          exp_err;
    int          exp_addr;
    logic [31:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        @(negedge clk);
        while (!byte_ready) begin
            waited++;
            if (waited > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_accept: byte 0x%0h not accepted in 100 cycles, required acceptance", b);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_valid);
        start      = 1'b1;
        byte_valid = with_valid;
        byte_in    = 8'h77;
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input int n, input logic [7:0] chk, input int gapmax);
        send_byte(len, $urandom_range(0, gapmax));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] w;
                w = fw[i] >> (24 - 8 * j);
                send_byte(w[7:0], $urandom_range(0, gapmax));
            end
        end
        send_byte(chk, $urandom_range(0, gapmax));
    endtask

    initial begin
        int base;
        n_checks   = 0;
        n_fail     = 0;
        wr_count   = 0;
        k          = 0;
        nwords     = 0;
        exp_wr     = 0;
        exp_fin    = 0;
        exp_err    = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        fork
            // compare process: predicts writes and completion from accepted bytes
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    k       = 0;
                    exp_wr  = 0;
                    exp_fin = 0;
                end else begin
                    check("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
                    if (wr_en) begin
                        wr_log[wr_addr] = wr_data;
                        last_wr_addr    = wr_addr;
                        last_wr_data    = wr_data;
                        wr_count++;
                        if (exp_wr) begin
                            check("wr_addr", 32'(wr_addr), 32'(exp_addr));
                            check("wr_data", wr_data, exp_data);
                            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
                        end
                    end
                    if (exp_fin) begin
                        check("fin_done", {31'd0, done}, 32'd1);
                        check("fin_busy", {31'd0, busy}, 32'd0);
                        check("fin_chk_err", {31'd0, chk_err}, {31'd0, exp_err});
                    end
                    exp_wr  = 0;
                    exp_fin = 0;
                    if (start && !busy) begin
                        k     = 0;
                        m_xor = 8'h00;
                    end
                    if (byte_valid && byte_ready) begin
                        if (k == 0) begin
                            nwords = (int'(byte_in) % DEPTH) + 1;
                            m_xor  = 8'h00;
                        end else if (k <= 4 * nwords) begin
                            m_word = {m_word[23:0], byte_in};
                            m_xor  = m_xor ^ byte_in;
                            if (k % 4 == 0) begin
                                exp_wr   = 1;
                                exp_addr = k / 4 - 1;
                                exp_data = m_word;
                            end
                        end else begin
                            exp_fin = 1;
                            exp_err = (byte_in != m_xor);
                        end
                        k++;
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached, required completion");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_chk_err", {31'd0, chk_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single word, start coinciding with a valid byte
        base  = wr_count;
        fw[0] = 32'hDEADBEEF;
        do_start(1'b1);
        send_frame(8'h00, 1, 8'h22, 0);
        @(negedge clk);
        check("t1_count", 32'(wr_count - base), 32'd1);
        check("t1_addr", 32'(last_wr_addr), 32'd0);
        check("t1_data", last_wr_data, 32'hDEADBEEF);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_chk_err", {31'd0, chk_err}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        tick();

        // three words
        base  = wr_count;
        fw[0] = 32'h1;
        fw[1] = 32'h2;
        fw[2] = 32'h3;
        do_start(1'b0);
        send_frame(8'h02, 3, 8'h00, 0);
        @(negedge clk);
        check("t2_count", 32'(wr_count - base), 32'd3);
        check("t2_w0", wr_log[0], 32'h1);
        check("t2_w1", wr_log[1], 32'h2);
        check("t2_w2", wr_log[2], 32'h3);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_chk_err", {31'd0, chk_err}, 32'd0);
        tick();

        // bad checksum, then a new start clears the flags
        base  = wr_count;
        fw[0] = 32'h12345678;
        do_start(1'b0);
        send_frame(8'h00, 1, 8'h00, 0);
        @(negedge clk);
        check("t3_count", 32'(wr_count - base), 32'd1);
        check("t3_w0", wr_log[0], 32'h12345678);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_chk_err", {31'd0, chk_err}, 32'd1);
        tick();
        do_start(1'b0);
        @(negedge clk);
        check("t3_clr_done", {31'd0, done}, 32'd0);
        check("t3_clr_chk_err", {31'd0, chk_err}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        tick();

        // three words with random source gaps, loader already in LEN
        base  = wr_count;
        fw[0] = 32'h1;
        fw[1] = 32'h2;
        fw[2] = 32'h3;
        wr_log[0] = '0;
        wr_log[1] = '0;
        wr_log[2] = '0;
        send_frame(8'h02, 3, 8'h00, 3);
        @(negedge clk);
        check("t4_count", 32'(wr_count - base), 32'd3);
        check("t4_w0", wr_log[0], 32'h1);
        check("t4_w1", wr_log[1], 32'h2);
        check("t4_w2", wr_log[2], 32'h3);
        check("t4_chk_err", {31'd0, chk_err}, 32'd0);
        tick();

        // oversize length 0x40 masks to a single word
        base  = wr_count;
        fw[0] = 32'hA5A5A5A5;
        do_start(1'b0);
        send_frame(8'h40, 1, 8'h00, 0);
        @(negedge clk);
        check("mask_count", 32'(wr_count - base), 32'd1);
        check("mask_data", last_wr_data, 32'hA5A5A5A5);
        check("mask_done", {31'd0, done}, 32'd1);
        tick();

        // full depth: 64 words, word i = i
        base = wr_count;
        for (int i = 0; i < DEPTH; i++) fw[i] = 32'(i);
        do_start(1'b0);
        send_frame(8'h3F, DEPTH, 8'h00, 0);
        @(negedge clk);
        check("full_count", 32'(wr_count - base), 32'd64);
        check("full_last_addr", 32'(last_wr_addr), 32'd63);
        check("full_w63", wr_log[63], 32'd63);
        check("full_w0", wr_log[0], 32'd0);
        check("full_chk_err", {31'd0, chk_err}, 32'd0);
        tick();

        // reset after the first word of a three-word frame
        fw[0] = 32'h11223344;
        do_start(1'b0);
        send_byte(8'h02, 0);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] w;
            w = fw[0] >> (24 - 8 * j);
            send_byte(w[7:0], 0);
        end
        @(negedge clk);
        @(posedge clk);
        #2;
        base       = wr_count;
        rst_n      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        #1;
        check("mid_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_chk_err", {31'd0, chk_err}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        byte_valid = 1'b0;
        check("mid_rst_no_writes", 32'(wr_count - base), 32'd0);
        check("mid_rst_idle_ready", {31'd0, byte_ready}, 32'd0);

        // clean load after reset restarts at address 0
        base  = wr_count;
        fw[0] = 32'hCAFEF00D;
        do_start(1'b0);
        send_frame(8'h00, 1, 8'hC9, 0);
        @(negedge clk);
        check("post_rst_count", 32'(wr_count - base), 32'd1);
        check("post_rst_addr", 32'(last_wr_addr), 32'd0);
        check("post_rst_data", last_wr_data, 32'hCAFEF00D);
        check("post_rst_chk_err", {31'd0, chk_err}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
